// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg: shared encodings for the Thumb LDM/STM/PUSH/POP sequencer.
//   LSM_OP_*    : op encodings (00 STM, 01 LDM, 10 PUSH, 11 POP)
//   LSM_*       : FSM state encodings
//   LSM_LIST_W  : register list width (R0-R7 plus LR/PC)
//   LR_I, PC_I  : register-file indices used for list bit 8
package ldm_stm_sequencer_pkg;
    localparam int LSM_LIST_W = 9;
    localparam logic [3:0] LR_I = 4'd14;
    localparam logic [3:0] PC_I = 4'd15;
    typedef enum logic [1:0] {
        LSM_OP_STM  = 2'b00,
        LSM_OP_LDM  = 2'b01,
        LSM_OP_PUSH = 2'b10,
        LSM_OP_POP  = 2'b11
    } lsm_op_e;
    typedef enum logic [2:0] {
        LSM_IDLE, LSM_SETUP, LSM_ACCESS, LSM_WB, LSM_DONE
    } lsm_state_e;
    function automatic logic is_store(lsm_op_e op);
        return op == LSM_OP_STM || op == LSM_OP_PUSH;
    endfunction
    function automatic logic is_stack(lsm_op_e op);
        return op == LSM_OP_PUSH || op == LSM_OP_POP;
    endfunction
    // List bit 8 is LR when pushing and PC when popping.
    function automatic logic [3:0] pos_to_reg(logic [3:0] pos, lsm_op_e op);
        return pos == 4'd8 ? (op == LSM_OP_PUSH ? LR_I : PC_I) : pos;
    endfunction
endpackage

// File: rtl/ldm_stm_sequencer_lsm_list_scan.sv
// lsm_list_scan: combinational register-list scanner.
//   i_list  : register list (bit 8 = LR/PC)
//   o_count : number of set bits
//   o_low   : bit position of the lowest set bit (0 when empty)
//   o_any   : list is non-empty
module lsm_list_scan
    import ldm_stm_sequencer_pkg::*;
(
    input  logic [LSM_LIST_W-1:0] i_list,
    output logic [3:0]            o_count,
    output logic [3:0]            o_low,
    output logic                  o_any
);
    always_comb begin
        o_count = '0;
        o_low   = '0;
        for (int i = LSM_LIST_W - 1; i >= 0; i--) begin
            o_count = o_count + 4'(i_list[i]);
            if (i_list[i]) o_low = 4'(i);
        end
    end
    assign o_any = |i_list;
endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle LDM/STM/PUSH/POP sequencer between decoder and register file.
// Optional feature macro: LSM_ALIGN_FAULT_EN (misaligned base -> fault+done, no access);
// without it base_val[1:0] is forced to 0 and fault stays 0.
//   clk, rst                        : clock, synchronous active-high reset
//   i_start/i_op/i_reg_list         : launch pulse, op, register list
//   i_base_idx/i_base_val           : base register index and value
//   o_rd_addr/i_rd_data             : register-file read port for stores
//   o_mem_req/we/addr/wdata         : memory request, held until i_mem_ack
//   i_mem_rdata/i_mem_ack           : load data and access completion
//   o_ld_rd/o_addr_rd/o_w_rd        : load write to R0-R7
//   o_ld_rn/o_addr_rn/o_w_rn        : base writeback (LDM/STM)
//   o_ld_sp/o_w_sp                  : SP update (PUSH/POP)
//   o_ld_pc/o_branch/o_w_pc         : POP {PC} branch
//   o_busy/o_done/o_fault           : status
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [LSM_LIST_W-1:0] i_reg_list,
    input  logic [3:0]            i_base_idx,
    input  logic [DATA_W-1:0]     i_base_val,
    output logic [3:0]            o_rd_addr,
    input  logic [DATA_W-1:0]     i_rd_data,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic                  o_ld_rd,
    output logic [3:0]            o_addr_rd,
    output logic [DATA_W-1:0]     o_w_rd,
    output logic                  o_ld_rn,
    output logic [3:0]            o_addr_rn,
    output logic [DATA_W-1:0]     o_w_rn,
    output logic                  o_ld_sp,
    output logic [DATA_W-1:0]     o_w_sp,
    output logic                  o_ld_pc,
    output logic                  o_branch,
    output logic [DATA_W-1:0]     o_w_pc,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fault
);
    lsm_state_e            r_state;
    lsm_op_e               r_op;
    logic [LSM_LIST_W-1:0] r_list;
    logic [DATA_W-1:0]     r_base, r_addr;
    logic [3:0]            r_n, r_pos;
    logic                  r_wait, r_base_in;
    logic [LSM_LIST_W-1:0] w_list_next, w_scan_in, w_eff_list;
    logic [3:0]            w_count, w_low;
    logic                  w_any, w_store, w_fault, w_base_in;
    logic [DATA_W-1:0]     w_span, w_base;
    lsm_op_e               w_op;

    assign w_op        = lsm_op_e'(i_op);
    assign w_eff_list  = is_stack(w_op) ? i_reg_list : {1'b0, i_reg_list[7:0]};
    assign w_base_in   = !i_base_idx[3] && i_reg_list[i_base_idx[2:0]];
    assign w_store     = is_store(r_op);
    assign w_list_next = r_list & (r_list - 1'b1);
    // During ACCESS the scanner looks ahead at the list with the current bit removed,
    // so the next read address is ready the cycle after mem_ack.
    assign w_scan_in   = r_state == LSM_ACCESS ? w_list_next : r_list;
    assign w_span      = DATA_W'(STEP) * DATA_W'(r_state == LSM_SETUP ? w_count : r_n);
`ifdef LSM_ALIGN_FAULT_EN
    assign w_base  = i_base_val;
    assign w_fault = |r_base[1:0];
`else
    assign w_base  = i_base_val & ~DATA_W'(3);
    assign w_fault = 1'b0;
`endif

    lsm_list_scan u_scan (
        .i_list  (w_scan_in),
        .o_count (w_count),
        .o_low   (w_low),
        .o_any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LSM_IDLE;
            r_op        <= LSM_OP_STM;
            r_list      <= '0;
            r_base      <= '0;
            r_addr      <= '0;
            r_n         <= '0;
            r_pos       <= '0;
            r_wait      <= 1'b0;
            r_base_in   <= 1'b0;
            o_rd_addr   <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_ld_rd     <= 1'b0;
            o_addr_rd   <= '0;
            o_w_rd      <= '0;
            o_ld_rn     <= 1'b0;
            o_addr_rn   <= '0;
            o_w_rn      <= '0;
            o_ld_sp     <= 1'b0;
            o_w_sp      <= '0;
            o_ld_pc     <= 1'b0;
            o_branch    <= 1'b0;
            o_w_pc      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            o_ld_rd  <= 1'b0;
            o_ld_pc  <= 1'b0;
            o_branch <= 1'b0;
            o_ld_rn  <= 1'b0;
            o_ld_sp  <= 1'b0;
            o_done   <= 1'b0;
            o_fault  <= 1'b0;
            case (r_state)
                LSM_IDLE: if (i_start) begin
                    r_state   <= LSM_SETUP;
                    o_busy    <= 1'b1;
                    r_op      <= w_op;
                    r_list    <= w_eff_list;
                    r_base    <= w_base;
                    r_base_in <= w_base_in;
                    o_addr_rn <= i_base_idx;
                end
                LSM_SETUP: begin
                    r_n       <= w_count;
                    r_addr    <= r_op == LSM_OP_PUSH ? r_base - w_span : r_base;
                    r_pos     <= w_low;
                    r_wait    <= 1'b0;
                    o_rd_addr <= w_store ? pos_to_reg(w_low, r_op) : '0;
                    if (!w_any || w_fault) begin
                        r_state <= LSM_DONE;
                        o_done  <= 1'b1;
                        o_fault <= w_fault;
                    end else begin
                        r_state <= LSM_ACCESS;
                    end
                end
                LSM_ACCESS: if (!r_wait) begin
                    o_mem_req   <= 1'b1;
                    o_mem_we    <= w_store;
                    o_mem_addr  <= r_addr;
                    o_mem_wdata <= w_store ? i_rd_data : '0;
                    r_wait      <= 1'b1;
                end else if (o_mem_req && i_mem_ack) begin
                    o_mem_req <= 1'b0;
                    r_wait    <= 1'b0;
                    r_list    <= w_list_next;
                    r_pos     <= w_low;
                    r_addr    <= r_addr + DATA_W'(STEP);
                    o_rd_addr <= w_store ? pos_to_reg(w_low, r_op) : '0;
                    if (!w_store && r_pos == 4'd8) begin
                        o_ld_pc  <= 1'b1;
                        o_branch <= 1'b1;
                        o_w_pc   <= {i_mem_rdata[DATA_W-1:1], 1'b0};
                    end else if (!w_store) begin
                        o_ld_rd   <= 1'b1;
                        o_addr_rd <= r_pos;
                        o_w_rd    <= i_mem_rdata;
                    end
                    if (!w_any) r_state <= LSM_WB;
                end
                LSM_WB: begin
                    r_state <= LSM_DONE;
                    o_done  <= 1'b1;
                    o_ld_sp <= is_stack(r_op);
                    // A loaded base register keeps the loaded value.
                    o_ld_rn <= !is_stack(r_op) && !(r_op == LSM_OP_LDM && r_base_in);
                    if (is_stack(r_op))
                        o_w_sp <= r_op == LSM_OP_PUSH ? r_base - w_span : r_base + w_span;
                    else
                        o_w_rn <= r_base + w_span;
                end
                LSM_DONE: begin
                    r_state <= LSM_IDLE;
                    o_busy  <= 1'b0;
                end
                default: r_state <= LSM_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: scoreboard bench for ldm_stm_sequencer with directed vectors.
module tb_ldm_stm_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, mem_req, mem_we, mem_ack;
    logic [1:0]  op;
    logic [8:0]  reg_list;
    logic [3:0]  base_idx, rd_addr, addr_rd, addr_rn;
    logic [31:0] base_val, rd_data, mem_addr, mem_wdata, mem_rdata, w_rd, w_rn, w_sp, w_pc;
    logic        ld_rd, ld_rn, ld_sp, ld_pc, branch, busy, done, fault;
    logic [213:0] all_o;

    typedef struct {int kind; logic we; logic [31:0] a; logic [31:0] d;} ev_t;
    localparam int REQ = 0, LDRD = 1, LDPC = 2, LDRN = 3, LDSP = 4, DONE = 5;
    localparam logic [31:0] DC = 32'hFFFF_FFFF;

    ev_t         expq[$];
    logic [31:0] rq[$];
    ev_t         cur;
    logic        prev_req = 1'b0;
    int          checks = 0, errors = 0, cyc = 0, t_start = 0, ack_dly = 1;

    always #5 clk = ~clk;
    assign rd_data = 32'hDA00_0000 | {28'h0, rd_addr};
    assign all_o = {busy, done, fault, rd_addr, mem_req, mem_we, mem_addr, mem_wdata,
                    ld_rd, addr_rd, w_rd, ld_rn, addr_rn, w_rn, ld_sp, w_sp, ld_pc, branch, w_pc};

    ldm_stm_sequencer dut (
        .clk(clk), .rst(rst), .i_start(start), .i_op(op), .i_reg_list(reg_list),
        .i_base_idx(base_idx), .i_base_val(base_val), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_ld_rd(ld_rd), .o_addr_rd(addr_rd), .o_w_rd(w_rd),
        .o_ld_rn(ld_rn), .o_addr_rn(addr_rn), .o_w_rn(w_rn),
        .o_ld_sp(ld_sp), .o_w_sp(w_sp), .o_ld_pc(ld_pc), .o_branch(branch), .o_w_pc(w_pc),
        .o_busy(busy), .o_done(done), .o_fault(fault)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic exp_ev(int k, logic we, logic [31:0] a, logic [31:0] d);
        expq.push_back('{k, we, a, d});
    endtask

    task automatic got(int k, logic we, logic [31:0] a, logic [31:0] d);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d we=%0b a=%h d=%h, required no event", k, we, a, d);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.we !== we || e.a !== a || (e.d != DC && e.d !== d)) begin
                errors++;
                $display("FAIL event: got kind=%0d we=%0b a=%h d=%h, required kind=%0d we=%0b a=%h d=%h",
                         k, we, a, d, e.kind, e.we, e.a, e.d);
            end
        end
    endtask

    // Monitor: every DUT output event is matched against the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mem_req && !prev_req) begin
                if (expq.size() > 0) cur = expq[0];
                got(REQ, mem_we, mem_addr, mem_wdata);
            end else if (mem_req) begin
                checks++;
                if (mem_we !== cur.we || mem_addr !== cur.a || mem_wdata !== cur.d) begin
                    errors++;
                    $display("FAIL req_hold: got we=%0b a=%h d=%h, required we=%0b a=%h d=%h",
                             mem_we, mem_addr, mem_wdata, cur.we, cur.a, cur.d);
                end
            end
            if (ld_rd) got(LDRD, 1'b0, {28'h0, addr_rd}, w_rd);
            if (ld_pc) got(LDPC, branch, 32'h0, w_pc);
            if (ld_rn) got(LDRN, 1'b0, {28'h0, addr_rn}, w_rn);
            if (ld_sp) got(LDSP, 1'b0, 32'h0, w_sp);
            if (done)  got(DONE, fault, 32'h0, 32'(cyc - t_start));
        end
        prev_req = mem_req;
    end

    // Memory responder: acks ack_dly cycles after a request appears.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                repeat (ack_dly) @(negedge clk);
                if (mem_req && !rst) begin
                    mem_ack = 1'b1;
                    mem_rdata = rq.size() > 0 ? rq.pop_front() : 32'h0;
                    @(negedge clk);
                    mem_ack = 1'b0;
                end
            end
        end
    end

    task automatic start_op(logic [1:0] o, logic [8:0] l, logic [3:0] bi, logic [31:0] b);
        @(negedge clk);
        op = o; reg_list = l; base_idx = bi; base_val = b; start = 1'b1; t_start = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_op(string name);
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_complete: %0d events pending busy=%0b, required 0 pending and idle", name, expq.size(), busy);
            expq.delete();
            rq.delete();
        end
    endtask

    task automatic check_zero(string name);
        checks++;
        if (all_o !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h, required all zero", name, all_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        start = 0; op = 0; reg_list = 0; base_idx = 0; base_val = 0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk) rst = 1'b0;

        // PUSH {R0,R1,LR}, SP=0x100
        exp_ev(REQ, 1, 32'hF4, 32'hDA00_0000);
        exp_ev(REQ, 1, 32'hF8, 32'hDA00_0001);
        exp_ev(REQ, 1, 32'hFC, 32'hDA00_000E);
        exp_ev(LDSP, 0, 0, 32'hF4);
        exp_ev(DONE, 0, 0, DC);
        start_op(2'b10, 9'h103, 4'd0, 32'h100);
        finish_op("push");

        // POP {R2,PC}, SP=0xF4
        rq.push_back(32'h11); rq.push_back(32'h205);
        exp_ev(REQ, 0, 32'hF4, 0);
        exp_ev(LDRD, 0, 2, 32'h11);
        exp_ev(REQ, 0, 32'hF8, 0);
        exp_ev(LDPC, 1, 0, 32'h204);
        exp_ev(LDSP, 0, 0, 32'hFC);
        exp_ev(DONE, 0, 0, DC);
        start_op(2'b11, 9'h104, 4'd0, 32'hF4);
        finish_op("pop_pc");

        // LDM R1!,{R1,R3} with bit8 set (ignored): base in list, no writeback
        rq.push_back(32'hAAAA_0001); rq.push_back(32'hBBBB_0003);
        exp_ev(REQ, 0, 32'h40, 0);
        exp_ev(LDRD, 0, 1, 32'hAAAA_0001);
        exp_ev(REQ, 0, 32'h44, 0);
        exp_ev(LDRD, 0, 3, 32'hBBBB_0003);
        exp_ev(DONE, 0, 0, DC);
        start_op(2'b01, 9'h10A, 4'd1, 32'h40);
        finish_op("ldm_base_in_list");

        // STM R0!,{R4}
        exp_ev(REQ, 1, 32'h40, 32'hDA00_0004);
        exp_ev(LDRN, 0, 0, 32'h44);
        exp_ev(DONE, 0, 0, DC);
        start_op(2'b00, 9'h010, 4'd0, 32'h40);
        finish_op("stm");

        // PUSH {R5,R7} with 3-cycle ack and stray starts while busy
        ack_dly = 3;
        exp_ev(REQ, 1, 32'h1F8, 32'hDA00_0005);
        exp_ev(REQ, 1, 32'h1FC, 32'hDA00_0007);
        exp_ev(LDSP, 0, 0, 32'h1F8);
        exp_ev(DONE, 0, 0, DC);
        start_op(2'b10, 9'h0A0, 4'd0, 32'h200);
        repeat (3) begin
            @(negedge clk);
            op = 2'b11; reg_list = 9'h1FF; base_val = 32'h500; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        finish_op("slow_ack");
        ack_dly = 1;

        // Empty lists: done two cycles after start
        exp_ev(DONE, 0, 0, 2);
        start_op(2'b00, 9'h000, 4'd0, 32'h80);
        finish_op("empty_stm");
        exp_ev(DONE, 0, 0, 2);
        start_op(2'b01, 9'h100, 4'd2, 32'h80);
        finish_op("empty_ldm_bit8");

        // Reset in the middle of a POP
        ack_dly = 3;
        rq.push_back(32'h1);
        exp_ev(REQ, 0, 32'h300, 0);
        start_op(2'b11, 9'h003, 4'd0, 32'h300);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!mem_req) begin
            errors++;
            $display("FAIL req_before_reset: mem_req=%0b, required 1", mem_req);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check_zero("reset_mid_pop");
        @(negedge clk) rst = 1'b0;
        expq.delete();
        rq.delete();
        ack_dly = 1;
        repeat (4) @(negedge clk);

        // Misaligned base 0x102
`ifdef LSM_ALIGN_FAULT_EN
        exp_ev(DONE, 1, 0, 2);
`else
        exp_ev(REQ, 1, 32'h100, 32'hDA00_0000);
        exp_ev(REQ, 1, 32'h104, 32'hDA00_0001);
        exp_ev(LDRN, 0, 2, 32'h108);
        exp_ev(DONE, 0, 0, DC);
`endif
        start_op(2'b00, 9'h003, 4'd2, 32'h102);
        finish_op("misaligned");

        // POP {R0,R1} across the address wrap
        rq.push_back(32'h5); rq.push_back(32'h6);
        exp_ev(REQ, 0, 32'hFFFF_FFFC, 0);
        exp_ev(LDRD, 0, 0, 32'h5);
        exp_ev(REQ, 0, 32'h0, 0);
        exp_ev(LDRD, 0, 1, 32'h6);
        exp_ev(LDSP, 0, 0, 32'h4);
        exp_ev(DONE, 0, 0, DC);
        start_op(2'b11, 9'h003, 4'd0, 32'hFFFF_FFFC);
        finish_op("pop_wrap");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
